// File: rtl/wby_bypass_register.sv
// Wrapper bypass register (WBY) for the P1500 wrapper around the s349 core.
// A chain of DEPTH flops between wby_si and q that shifts on wby_shift and
// holds otherwise. Build option WBY_CAPTURE_EN adds a wby_capture port that
// loads CAPTURE_VALUE[0] into every stage when not shifting.
module wby_bypass_register #(
  parameter int unsigned DEPTH         = 1,
  parameter logic [31:0] CAPTURE_VALUE = 32'd0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wby_si,
  input  logic wby_shift,
`ifdef WBY_CAPTURE_EN
  input  logic wby_capture,
`endif
  output logic q
);

  // Reject out-of-range chain lengths at elaboration.
  if (DEPTH < 1 || DEPTH > 16) begin : g_depth_check
    $error("wby_bypass_register: DEPTH must be in 1..16");
  end

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  // Next-state: shift takes priority over capture; otherwise every stage recirculates.
  always_comb begin
    stage_d = stage_q;
    if (wby_shift) begin
      stage_d[0] = wby_si;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
`ifdef WBY_CAPTURE_EN
    else if (wby_capture) begin
      stage_d = {DEPTH{CAPTURE_VALUE[0]}};
    end
`endif
  end

  // Stage flops; reset clears the whole chain immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Output comes straight from the last flop, never from an input.
  always_comb begin
    q = stage_q[DEPTH-1];
  end

endmodule

// File: tb/tb_wby_bypass_register.sv
// Directed bench for wby_bypass_register: one DEPTH=1 and one DEPTH=4 instance.
// Capture checks are compiled in only when WBY_CAPTURE_EN is defined.
module tb_wby_bypass_register;

  logic clk = 1'b0;
  logic rst_n;
  logic si1, sh1, q1;
  logic si4, sh4, q4;
`ifdef WBY_CAPTURE_EN
  logic cap1, cap4;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wby_bypass_register #(.DEPTH(1), .CAPTURE_VALUE(32'd0)) u_d1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wby_si     (si1),
    .wby_shift  (sh1),
`ifdef WBY_CAPTURE_EN
    .wby_capture(cap1),
`endif
    .q          (q1)
  );

  wby_bypass_register #(.DEPTH(4), .CAPTURE_VALUE(32'd0)) u_d4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wby_si     (si4),
    .wby_shift  (sh4),
`ifdef WBY_CAPTURE_EN
    .wby_capture(cap4),
`endif
    .q          (q4)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] bits4;
  logic [6:0] exp4;
  logic [8:0] gap_si;
  logic [8:0] gap_sh;
  logic [8:0] gap_exp;

  initial begin
`ifdef WBY_CAPTURE_EN
    cap1 = 1'b0;
    cap4 = 1'b0;
`endif
    // Reset held with shift active and si=1: q must stay 0.
    rst_n = 1'b0;
    si1 = 1'b1; sh1 = 1'b1;
    si4 = 1'b1; sh4 = 1'b1;
    #1;
    chk("rst_t0_d1", q1, 1'b0);
    chk("rst_t0_d4", q4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_edge%0d_d1", i), q1, 1'b0);
      chk($sformatf("rst_edge%0d_d4", i), q4, 1'b0);
    end
    rst_n = 1'b1;
    si4 = 1'b0; sh4 = 1'b0;

    // DEPTH=1 hold, then shift a 1.
    si1 = 1'b1; sh1 = 1'b0;
    step(); chk("d1_hold_a", q1, 1'b0);
    step(); chk("d1_hold_b", q1, 1'b0);
    sh1 = 1'b1;
    step(); chk("d1_shift1", q1, 1'b1);
    // Hold against input change.
    si1 = 1'b0; sh1 = 1'b0;
    step(); chk("d1_hold1_a", q1, 1'b1);
    step(); chk("d1_hold1_b", q1, 1'b1);
    si1 = 1'b1;
    step(); chk("d1_hold1_c", q1, 1'b1);
    // Shift a 0 then hold with si=1.
    si1 = 1'b0; sh1 = 1'b1;
    step(); chk("d1_shift0", q1, 1'b0);
    si1 = 1'b1; sh1 = 1'b0;
    step(); chk("d1_hold0", q1, 1'b0);
    // X on si during hold stays out of the stage.
    si1 = 1'bx;
    step(); chk("d1_hold_x", q1, 1'b0);
    // Mid-cycle wiggle with shift dropped before the edge.
    si1 = 1'b1; sh1 = 1'b1;
    #2; sh1 = 1'b0;
    step(); chk("d1_between_edges", q1, 1'b0);
    si1 = 1'b0;

    // DEPTH=4 straight shift of 1,0,1,1 then zeros (bit 6 first).
    bits4 = 7'b1011000;
    exp4  = 7'b0001011;
    sh4 = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      si4 = bits4[i];
      step();
      chk($sformatf("d4_stream_e%0d", 7 - i), q4, exp4[i]);
    end
    sh4 = 1'b0;

    // Async reset mid-shift while q4=1 clears without a clock edge.
    sh4 = 1'b1; si4 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("d4_async_rst", q4, 1'b0);
    step();
    chk("d4_rst_held", q4, 1'b0);
    rst_n = 1'b1;
    sh4 = 1'b0; si4 = 1'b0;

    // DEPTH=4 with 2 hold cycles after the second bit (bit 8 first).
    gap_si  = 9'b10_11_11000;
    gap_sh  = 9'b11_00_11111;
    gap_exp = 9'b00_00_01011;
    for (int i = 8; i >= 0; i--) begin
      si4 = gap_si[i];
      sh4 = gap_sh[i];
      step();
      chk($sformatf("d4_gap_e%0d", 9 - i), q4, gap_exp[i]);
    end
    sh4 = 1'b0;

`ifdef WBY_CAPTURE_EN
    // Preload ones, capture loads CAPTURE_VALUE[0]=0.
    si4 = 1'b1; sh4 = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("cap_preload", q4, 1'b1);
    sh4 = 1'b0; cap4 = 1'b1;
    step(); chk("cap_load", q4, 1'b0);
    cap4 = 1'b0;
    step(); chk("cap_hold", q4, 1'b0);
    // Preload ones again; capture with shift must shift.
    sh4 = 1'b1;
    for (int i = 0; i < 4; i++) step();
    cap4 = 1'b1;
    step(); chk("cap_shift_wins", q4, 1'b1);
    cap4 = 1'b0; sh4 = 1'b0;
    // DEPTH=1 capture clears a held 1.
    si1 = 1'b1; sh1 = 1'b1;
    step(); chk("cap_d1_pre", q1, 1'b1);
    sh1 = 1'b0; cap1 = 1'b1;
    step(); chk("cap_d1_load", q1, 1'b0);
    cap1 = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
